fm_phase_gen: RTL and testbench
===============================

Name: fm_phase_gen

Overview:
- Parametrised, self-sequencing phase generator for the FM synth; next generation of the per-operator phase accumulator.
- On each sample-frame `start` pulse it scans all NUM_OPS operators, fetches each operator's parameters through a 1-cycle-latency read port, updates a private phase RAM and streams out one phase value per operator.
- Adds over the previous generation: post-reset RAM clear sweep, key-on edge detection for restart, frame-rate vibrato counter, configurable widths and operator count.
- Sits between the FM register file (parameter source) and the waveform/envelope stage (phase consumer).

Parameters:
- NUM_OPS, 36, operators per frame (2..2^OP_W).
- OP_W, 6, operator index width.
- ACC_W, 19, phase accumulator width.
- PH_W, 10, output phase width; output is acc[ACC_W-1 -: PH_W].
- VIB_W, 13, vibrato counter width (>=3).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  begin frame scan; honoured only when idle.
- busy  out  1  high during INIT sweep or SCAN.
- done  out  1  one-cycle pulse after the last operator is written.
- param_idx  out  OP_W  operator whose parameters are requested.
- block  in  3  octave for the operator at param_idx, valid 1 cycle after it is presented.
- fnum  in  10  F-number, same timing as block.
- mult  in  4  MULT code, same timing as block.
- keyon  in  1  key-on level, same timing as block.
- dvb  in  1  deep vibrato, same timing as block.
- vib  in  1  vibrato enable, same timing as block.
- phase_valid  out  1  phase_out / phase_idx valid.
- phase_idx  out  OP_W  operator index of phase_out.
- phase_out  out  PH_W  operator phase for this frame.

Behaviour:
- Reset values:
  - busy=1; done=0; phase_valid=0; phase_idx=0; phase_out=0; param_idx=0.
  - Vibrato counter = 0; keyon history vector (NUM_OPS bits) = 0.
  - State = INIT.
- States:
  - INIT: writes 0 to phase RAM entries 0..NUM_OPS-1, one per cycle (NUM_OPS cycles). Then IDLE, busy=0. `start` during INIT is ignored.
  - IDLE: busy=0. `start` -> SCAN with idx=0 on the next edge.
  - SCAN: idx increments each cycle; param_idx=idx. After issuing idx=NUM_OPS-1, go to DRAIN.
  - DRAIN: waits for pipeline completion. On the cycle the last write occurs, done=1, vibrato counter +1 (wraps modulo 2^VIB_W), then IDLE.
- Pipeline for operator k:
  - Cycle t: param_idx=k; phase RAM read of k issued.
  - Cycle t+1: params and RAM data q valid.
    - restart = keyon & ~hist[k]; hist[k] <= keyon.
    - base = restart ? 0 : q.
    - Write base+inc to entry k.
  - Cycle t+2: phase_valid=1, phase_idx=k, phase_out=base[ACC_W-1 -: PH_W].
  - Throughput is one operator per cycle; read and write addresses never collide (write k, read k+1).
- Increment arithmetic:
  - mult map 0..15 -> 1,2,4,6,8,10,12,14,16,18,20,20,24,24,30,30.
  - inc_base = ((fnum << block) * multval), truncated to ACC_W bits.
  - delta = fnum[9:7].
    - Shift right 1 if vibcnt[VIB_W-2:VIB_W-3]==3.
    - Shift right 1 more if dvb=0.
  - vinc = {0,delta} zero-extended to ACC_W; bitwise inverted when vibcnt[VIB_W-1]=1.
  - inc = inc_base + (vib ? vinc : 0), modulo 2^ACC_W. Accumulator wraps silently.
- Boundaries:
  - keyon held high across frames restarts only in the first frame.
  - keyoff clears hist without touching phase.
  - `start` while busy is ignored (not queued).
  - `start` coincident with done is ignored.
  - Reset mid-SCAN aborts the scan and forces INIT. No done pulse is emitted and phase_valid drops immediately.

Test Plan:
- Reset, then drive params all 0 -> busy high exactly NUM_OPS cycles; first frame outputs phase_out=0 for all 36 ops, phase_idx 0..35 contiguous, done 2 cycles after last param_idx.
- Op 3: fnum=1, block=0, mult=1 (x2), vib=0, ACC_W=19 -> after 256 frames phase_out=1 (acc=512) at idx 3.
- Op 0: fnum=0x200, block=7, mult=15 -> inc = (0x10000*30) mod 2^19 = 0x60000; frames show acc 0, 0x60000, 0x40000 (wrap), 0x20000.
- Keyon 0->1 on op 5 with accumulated phase -> that frame phase_out=0; next frames accumulate normally; keyon held 1 gives no further restart.
- vib=1, dvb=1, fnum=0x380, force vibcnt MSB=1 -> inc = inc_base - 8 (0x7FFF8 added).
- `start` pulsed mid-scan is ignored (one done only); reset asserted at idx 10 -> phase_valid=0 next cycle, busy stays high for NUM_OPS cycles, then phase RAM reads 0.

Source files
------------

// File: rtl/fm_phase_gen_if.sv
// Parameter-fetch / phase-stream bundle of the FM phase generator.
//   master : the phase generator (drives busy, done, param_idx, phase_*;
//            receives start and the operator parameters)
//   slave  : the surrounding system (register file side + phase consumer)
//   start       frame scan request
//   busy, done  sweep / scan status, frame-complete pulse
//   param_idx   operator whose parameters are requested
//   block, fnum, mult, keyon, dvb, vib
//               operator parameters, valid one cycle after param_idx
//   phase_valid, phase_idx, phase_out
//               per-operator phase stream
interface fm_phase_gen_if #(
    parameter int OP_W = 6,
    parameter int PH_W = 10
) ();
    logic            start;
    logic            busy;
    logic            done;
    logic [OP_W-1:0] param_idx;
    logic [2:0]      block;
    logic [9:0]      fnum;
    logic [3:0]      mult;
    logic            keyon;
    logic            dvb;
    logic            vib;
    logic            phase_valid;
    logic [OP_W-1:0] phase_idx;
    logic [PH_W-1:0] phase_out;

    modport master (
        input  start, block, fnum, mult, keyon, dvb, vib,
        output busy, done, param_idx, phase_valid, phase_idx, phase_out
    );

    modport slave (
        output start, block, fnum, mult, keyon, dvb, vib,
        input  busy, done, param_idx, phase_valid, phase_idx, phase_out
    );
endinterface

// File: rtl/fm_phase_gen.sv
// Self-sequencing per-operator phase generator for the FM synth.
// After reset the private phase RAM is swept to zero (busy high). Each
// start pulse received while idle scans all NUM_OPS operators: parameters
// are fetched through a 1-cycle-latency read port, the phase RAM entry is
// advanced by the operator increment (with optional vibrato) and the
// pre-update phase is streamed out, one operator per cycle.
// Ports:
//   clk    clock
//   reset  asynchronous, active-high; aborts any scan and restarts the sweep
//   bus    fm_phase_gen_if.master (start/busy/done, parameter fetch,
//          phase stream)
module fm_phase_gen #(
    parameter int NUM_OPS = 36,
    parameter int OP_W    = 6,
    parameter int ACC_W   = 19,
    parameter int PH_W    = 10,
    parameter int VIB_W   = 13
) (
    input  logic          clk,
    input  logic          reset,
    fm_phase_gen_if.master bus
);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_SCAN, S_DRAIN} state_t;

    localparam logic [OP_W-1:0] LAST = OP_W'(NUM_OPS - 1);
    // (fnum << 7) * 30 fits in 22 bits; widen only if the accumulator is wider
    localparam int PROD_W = (ACC_W > 22) ? ACC_W : 22;

    function automatic logic [4:0] mult_val(input logic [3:0] m);
        case (m)
            4'd0:    mult_val = 5'd1;
            4'd1:    mult_val = 5'd2;
            4'd2:    mult_val = 5'd4;
            4'd3:    mult_val = 5'd6;
            4'd4:    mult_val = 5'd8;
            4'd5:    mult_val = 5'd10;
            4'd6:    mult_val = 5'd12;
            4'd7:    mult_val = 5'd14;
            4'd8:    mult_val = 5'd16;
            4'd9:    mult_val = 5'd18;
            4'd10:   mult_val = 5'd20;
            4'd11:   mult_val = 5'd20;
            4'd12:   mult_val = 5'd24;
            4'd13:   mult_val = 5'd24;
            default: mult_val = 5'd30;
        endcase
    endfunction

    // Vibrato offset: magnitude from the top F-number bits, halved near the
    // vibrato peak and again for shallow depth; the negative half-cycle uses
    // the one's complement so the accumulator add subtracts (delta+1).
    function automatic logic [ACC_W-1:0] vib_offset(input logic [9:0]       f,
                                                    input logic             deep,
                                                    input logic [VIB_W-1:0] vc);
        logic [2:0] d;
        d = f[9:7];
        if (vc[VIB_W-2:VIB_W-3] == 2'b11) d = d >> 1;
        if (!deep)                         d = d >> 1;
        vib_offset = ACC_W'({1'b0, d});
        if (vc[VIB_W-1]) vib_offset = ~vib_offset;
    endfunction

    state_t             state;
    logic [OP_W-1:0]    idx_p0;
    logic               busy_r;
    logic               done_r;
    logic [VIB_W-1:0]   vibcnt;
    logic [NUM_OPS-1:0] hist;
    logic [ACC_W-1:0]   ram [NUM_OPS];

    logic               vld_p1;
    logic [OP_W-1:0]    idx_p1;
    logic [ACC_W-1:0]   q_p1;
    logic [PROD_W-1:0]  prod_p1;
    logic [ACC_W-1:0]   inc_p1;
    logic [ACC_W-1:0]   base_p1;
    logic [ACC_W-1:0]   sum_p1;
    logic               restart_p1;

    logic               vld_p2;
    logic [OP_W-1:0]    phase_idx_p2;
    logic [PH_W-1:0]    phase_out_p2;

    // ---- stage p0 -> p1: RAM read of the operator presented on param_idx
    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            ram[idx_p0] <= '0;
        end else if (vld_p1) begin
            ram[idx_p1] <= sum_p1;
        end
        q_p1   <= ram[idx_p0];
        idx_p1 <= idx_p0;
    end

    // ---- stage p1: parameters and RAM data meet; compute the update
    always_comb begin
        restart_p1 = bus.keyon & ~hist[idx_p1];
        base_p1    = restart_p1 ? '0 : q_p1;
        prod_p1    = (PROD_W'(bus.fnum) << bus.block) * PROD_W'(mult_val(bus.mult));
        inc_p1     = prod_p1[ACC_W-1:0]
                   + (bus.vib ? vib_offset(bus.fnum, bus.dvb, vibcnt) : '0);
        sum_p1     = base_p1 + inc_p1;
    end

    // ---- control and stage p1 -> p2 output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_INIT;
            idx_p0       <= '0;
            busy_r       <= 1'b1;
            done_r       <= 1'b0;
            vibcnt       <= '0;
            hist         <= '0;
            vld_p1       <= 1'b0;
            vld_p2       <= 1'b0;
            phase_idx_p2 <= '0;
            phase_out_p2 <= '0;
        end else begin
            done_r <= 1'b0;
            vld_p1 <= (state == S_SCAN);
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                hist[idx_p1] <= bus.keyon;
                phase_idx_p2 <= idx_p1;
                phase_out_p2 <= base_p1[ACC_W-1 -: PH_W];
            end
            case (state)
                S_INIT: begin
                    if (idx_p0 == LAST) begin
                        idx_p0 <= '0;
                        state  <= S_IDLE;
                        busy_r <= 1'b0;
                    end else begin
                        idx_p0 <= idx_p0 + 1'b1;
                    end
                end
                S_IDLE: begin
                    // done_r marks the frame-end cycle; a start there is dropped
                    if (bus.start && !done_r) begin
                        state  <= S_SCAN;
                        busy_r <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (idx_p0 == LAST) begin
                        idx_p0 <= '0;
                        state  <= S_DRAIN;
                    end else begin
                        idx_p0 <= idx_p0 + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (vld_p1 && idx_p1 == LAST) begin
                        done_r <= 1'b1;
                        vibcnt <= vibcnt + 1'b1;
                        state  <= S_IDLE;
                        busy_r <= 1'b0;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.param_idx   = idx_p0;
    assign bus.phase_valid = vld_p2;
    assign bus.phase_idx   = phase_idx_p2;
    assign bus.phase_out   = phase_out_p2;

endmodule

// File: tb/tb_fm_phase_gen.sv
// Directed bench for fm_phase_gen (36 operators, 19-bit accumulator,
// 4-bit vibrato counter so the vibrato polarity is reachable quickly).
module tb_fm_phase_gen;
    localparam int N = 36;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fm_phase_gen_if #(.OP_W(6), .PH_W(10)) bus ();

    fm_phase_gen #(
        .NUM_OPS(N), .OP_W(6), .ACC_W(19), .PH_W(10), .VIB_W(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;
    int frames   = 0;
    int cyc      = 0;

    // register-file model
    logic [9:0] t_fnum  [N];
    logic [2:0] t_block [N];
    logic [3:0] t_mult  [N];
    logic       t_keyon [N];
    logic       t_dvb   [N];
    logic       t_vib   [N];

    // recorded output stream
    int         nvalid = 0;
    int         obs_idx [64];
    logic [9:0] obs_phase [N];
    int         first_vcyc = 0, last_vcyc = 0;
    int         done_cnt = 0, done_cyc = 0, last_pidx_cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // parameters answer the index presented in the previous cycle
    initial begin : param_drv
        int prev;
        prev = 0;
        bus.fnum = '0; bus.block = '0; bus.mult = '0;
        bus.keyon = 1'b0; bus.dvb = 1'b0; bus.vib = 1'b0;
        forever begin
            @(negedge clk);
            if (prev >= 0 && prev < N) begin
                bus.fnum  = t_fnum[prev];
                bus.block = t_block[prev];
                bus.mult  = t_mult[prev];
                bus.keyon = t_keyon[prev];
                bus.dvb   = t_dvb[prev];
                bus.vib   = t_vib[prev];
            end
            prev = int'(bus.param_idx);
        end
    end

    initial forever begin
        @(negedge clk);
        if (bus.phase_valid === 1'b1) begin
            if (nvalid < 64) obs_idx[nvalid] = int'(bus.phase_idx);
            if (nvalid == 0) first_vcyc = cyc;
            last_vcyc = cyc;
            if (int'(bus.phase_idx) < N) obs_phase[int'(bus.phase_idx)] = bus.phase_out;
            nvalid++;
        end
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.busy === 1'b1 && int'(bus.param_idx) == N - 1) last_pidx_cyc = cyc;
    end

    initial begin
        #900000;
        $display("FAIL watchdog time_limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_params();
        for (int i = 0; i < N; i++) begin
            t_fnum[i] = '0; t_block[i] = '0; t_mult[i] = '0;
            t_keyon[i] = 1'b0; t_dvb[i] = 1'b0; t_vib[i] = 1'b0;
        end
    endtask

    task automatic run_frame();
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        nvalid   = 0;
        done_cnt = 0;
        for (int i = 0; i < N; i++) obs_phase[i] = 'x;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.done !== 1'b1) begin
            failures++;
            $display("FAIL frame_timeout done=%b required=1", bus.done);
        end else begin
            frames++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        int n;
        clear_params();
        bus.start = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL rst_busy got=%b exp=1", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", bus.done); end
        checks++; if (bus.phase_valid !== 1'b0) begin failures++; $display("FAIL rst_phase_valid got=%b exp=0", bus.phase_valid); end
        checks++; if (bus.param_idx !== 6'd0) begin failures++; $display("FAIL rst_param_idx got=%0d exp=0", bus.param_idx); end
        checks++; if (bus.phase_idx !== 6'd0) begin failures++; $display("FAIL rst_phase_idx got=%0d exp=0", bus.phase_idx); end
        checks++; if (bus.phase_out !== 10'd0) begin failures++; $display("FAIL rst_phase_out got=%0d exp=0", bus.phase_out); end
        nvalid = 0;
        reset = 1'b0;
        frames = 0;
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            bus.start = (n == 5);
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        checks++; if (n != N) begin failures++; $display("FAIL init_busy_cycles got=%0d exp=%0d", n, N); end
        repeat (10) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL init_start_ignored busy=%b exp=0", bus.busy); end
        checks++; if (nvalid != 0) begin failures++; $display("FAIL init_no_output got=%0d exp=0", nvalid); end
    endtask

    task automatic test_zero_frame();
        int bad;
        run_frame();
        checks++; if (nvalid != N) begin failures++; $display("FAIL zero_count got=%0d exp=%0d", nvalid, N); end
        bad = 0;
        for (int i = 0; i < N; i++) begin
            if (obs_idx[i] != i) bad++;
            if (obs_phase[i] !== 10'd0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL zero_seq_values bad=%0d exp=0", bad); end
        checks++; if (last_vcyc - first_vcyc != N - 1) begin failures++; $display("FAIL zero_contiguous span=%0d exp=%0d", last_vcyc - first_vcyc, N - 1); end
        checks++; if (done_cyc - last_pidx_cyc != 2) begin failures++; $display("FAIL done_latency got=%0d exp=2", done_cyc - last_pidx_cyc); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL zero_done_count got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_wrap();
        int exp_w[5];
        exp_w = '{0, 'h300, 'h200, 'h100, 0};
        t_fnum[0] = 10'h200; t_block[0] = 3'd7; t_mult[0] = 4'd15;
        for (int f = 0; f < 5; f++) begin
            run_frame();
            checks++;
            if (obs_phase[0] !== 10'(exp_w[f])) begin
                failures++;
                $display("FAIL wrap_frame%0d got=%h exp=%h", f, obs_phase[0], exp_w[f]);
            end
        end
        t_fnum[0] = '0; t_block[0] = '0; t_mult[0] = '0;
    endtask

    task automatic test_slow_accum();
        t_fnum[3] = 10'd1; t_block[3] = 3'd0; t_mult[3] = 4'd1;
        for (int f = 0; f <= 256; f++) begin
            run_frame();
            if (f == 255) begin
                checks++;
                if (obs_phase[3] !== 10'd0) begin failures++; $display("FAIL slow_frame255 got=%0d exp=0", obs_phase[3]); end
            end
            if (f == 256) begin
                checks++;
                if (obs_phase[3] !== 10'd1) begin failures++; $display("FAIL slow_frame256 got=%0d exp=1", obs_phase[3]); end
            end
        end
        t_fnum[3] = '0; t_mult[3] = '0;
    endtask

    task automatic test_vibrato();
        int exp_v[5];
        int k;
        exp_v = '{0, 1, 3, 5, 6};
        k = 0;
        while ((frames % 16) != 8 && k < 40) begin
            run_frame();
            k++;
        end
        // inc_base 896, negative vibrato half: 896 - 8 = 888 per frame
        t_fnum[7] = 10'h380; t_block[7] = 3'd0; t_mult[7] = 4'd0;
        t_vib[7] = 1'b1; t_dvb[7] = 1'b1;
        for (int f = 0; f < 5; f++) begin
            run_frame();
            checks++;
            if (obs_phase[7] !== 10'(exp_v[f])) begin
                failures++;
                $display("FAIL vib_frame%0d got=%0d exp=%0d", f, obs_phase[7], exp_v[f]);
            end
        end
        t_fnum[7] = '0; t_vib[7] = 1'b0; t_dvb[7] = 1'b0;
    endtask

    task automatic test_keyon();
        logic kon[8];
        int   exp_k[8];
        kon   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_k = '{0, 8, 16, 0, 8, 16, 24, 0};
        t_fnum[5] = 10'h100; t_block[5] = 3'd3; t_mult[5] = 4'd1;
        for (int f = 0; f < 8; f++) begin
            t_keyon[5] = kon[f];
            run_frame();
            checks++;
            if (obs_phase[5] !== 10'(exp_k[f])) begin
                failures++;
                $display("FAIL keyon_frame%0d got=%0d exp=%0d", f, obs_phase[5], exp_k[f]);
            end
        end
        t_fnum[5] = '0; t_block[5] = '0; t_mult[5] = '0; t_keyon[5] = 1'b0;
    endtask

    task automatic test_start_ignored();
        int n;
        nvalid = 0;
        done_cnt = 0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (!(bus.busy === 1'b1 && int'(bus.param_idx) == 10) && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        frames++;
        repeat (60) @(negedge clk);
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL start_ignored_done got=%0d exp=1", done_cnt); end
        checks++; if (nvalid != N) begin failures++; $display("FAIL start_ignored_outputs got=%0d exp=%0d", nvalid, N); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL start_ignored_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_reset_mid_scan();
        int n;
        int bad;
        done_cnt = 0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (!(bus.busy === 1'b1 && int'(bus.param_idx) == 10) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++; if (bus.phase_valid !== 1'b1) begin failures++; $display("FAIL midscan_valid_before got=%b exp=1", bus.phase_valid); end
        reset = 1'b1;
        #1;
        checks++; if (bus.phase_valid !== 1'b0) begin failures++; $display("FAIL midscan_valid_drop got=%b exp=0", bus.phase_valid); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL midscan_busy got=%b exp=1", bus.busy); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        frames = 0;
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n != N) begin failures++; $display("FAIL midscan_init_cycles got=%0d exp=%0d", n, N); end
        checks++; if (done_cnt != 0) begin failures++; $display("FAIL midscan_no_done got=%0d exp=0", done_cnt); end
        clear_params();
        run_frame();
        bad = 0;
        for (int i = 0; i < N; i++) if (obs_phase[i] !== 10'd0) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL midscan_ram_cleared bad=%0d exp=0", bad); end
    endtask

    initial begin
        bus.start = 1'b0;
        test_reset();
        test_zero_frame();
        test_wrap();
        test_slow_accum();
        test_vibrato();
        test_keyon();
        test_start_ignored();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
